soc_system_sw_debounce: RTL and testbench
=========================================

// Module: soc_system_sw_debounce
// PURPOSE
//   Conditions raw board slide-switch inputs before they reach the switch PIO
//   input port. Each bit gets a 2-FF synchronizer and a per-bit debounce counter.
//   Outputs are a clean, glitch-free switch vector plus one-cycle rise/fall
//   pulses for HPS-side edge logic. The block sits directly upstream of the
//   switch PIO slave: sw_stable drives the PIO in_port.
// PARAMETERS
//   WIDTH            10      number of switch bits
//   DEBOUNCE_CYCLES  500000  clock cycles a new level must persist before it
//                            is accepted (10 ms at 50 MHz); legal range >= 2
//   CNT_W            20      counter width; must satisfy 2**CNT_W >= DEBOUNCE_CYCLES
// PORTS
//   clk         in   1      system clock; all logic on its rising edge
//   reset       in   1      asynchronous, active-high reset
//   sw_raw      in   WIDTH  asynchronous switch pins
//   sw_stable   out  WIDTH  debounced switch levels; drives PIO in_port
//   sw_rise     out  WIDTH  1-cycle pulse per bit on accepted 0->1
//   sw_fall     out  WIDTH  1-cycle pulse per bit on accepted 1->0
//   sw_changed  out  1      1-cycle pulse: OR of sw_rise|sw_fall
// BEHAVIOUR
//   - Reset: one clock, asynchronous, active-high. While reset is high, the
//     sync stages, counters, sw_stable, sw_rise, sw_fall and sw_changed are
//     all 0. Release takes effect on the next clk edge.
//   - Synchronizer: sync1 <= sw_raw; sync2 <= sync1. Only sync2 is used
//     downstream. sync1 must never fan out elsewhere.
//   - Per bit i, at each clk edge:
//       * sync2[i] == sw_stable[i]: cnt[i] <= 0; no pulse.
//       * sync2[i] != sw_stable[i] and cnt[i] < DEBOUNCE_CYCLES-1:
//         cnt[i] <= cnt[i]+1.
//       * sync2[i] != sw_stable[i] and cnt[i] == DEBOUNCE_CYCLES-1:
//         sw_stable[i] <= sync2[i]; cnt[i] <= 0; assert sw_rise[i] or
//         sw_fall[i] for exactly this one cycle.
//   - Pulse alignment: pulses are registered and high in the same cycle
//     sw_stable first shows the new value. Otherwise they are 0.
//   - sw_changed is registered together with the pulses, not derived
//     combinationally from the pulse outputs.
//   - Latency: a clean level change sampled into sync1 at edge k updates
//     sw_stable at edge k+1+DEBOUNCE_CYCLES.
//   - Glitch rejection: any return of sync2[i] to sw_stable[i] before the
//     count completes clears cnt[i]. A pulse train whose high time is shorter
//     than DEBOUNCE_CYCLES never changes the output.
//   - Independence: bits debounce independently. Several bits may update and
//     pulse in the same cycle.
//   - Counter saturation: cnt never exceeds DEBOUNCE_CYCLES-1, so there is
//     no wrap-around.
//   - Post-reset: a switch held at 1 through reset is accepted
//     DEBOUNCE_CYCLES+2 cycles after release and produces one sw_rise pulse.
//     This is intended behaviour; there is no startup suppression.
//   - Reset mid-count: counters clear; no pulse is emitted.
// TESTING  (bench uses DEBOUNCE_CYCLES=4, WIDTH=10)
//   1. Reset with sw_raw=10'h000, then hold -> sw_stable=0 and no pulses
//      for 50 cycles.
//   2. Drive sw_raw[0] 0->1 and hold -> sw_stable=10'h001 exactly 6 edges
//      after the input edge, with sw_rise=10'h001 and sw_changed=1 for 1 cycle.
//   3. Bounce sw_raw[3] high 3 cycles, low 1, high 3, low -> sw_stable[3]
//      stays 0 and sw_rise/sw_fall stay 0.
//   4. Change 10'h000->10'h3FF in one cycle -> all bits update on the same
//      edge, sw_rise=10'h3FF for 1 cycle. Then 10'h3FF->10'h155 ->
//      sw_fall=10'h2AA.
//   5. Hold sw_raw=10'h081 through reset -> after release, sw_stable=10'h081
//      at cycle 6 with a single sw_rise=10'h081 pulse.
//   6. Assert reset while sw_raw[5] is mid-count (cnt=2) -> outputs are
//      immediately 0 with no pulse; re-debounce completes 6 cycles after
//      release.

Source files
------------

// File: rtl/soc_system_sw_debounce.sv
// Slide-switch conditioner: 2-FF synchronizer plus per-bit debounce counter,
// producing a clean level vector and registered one-cycle rise/fall/changed pulses.
module soc_system_sw_debounce #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             changed_q, changed_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Next-state: count while the synchronized level disagrees, accept at terminal count.
  always_comb begin
    stable_d = stable_q;
    rise_d   = {WIDTH{1'b0}};
    fall_d   = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = CNT_ZERO;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = sync2_q[i];
          cnt_d[i]    = CNT_ZERO;
          rise_d[i]   = sync2_q[i];
          fall_d[i]   = ~sync2_q[i];
        end else begin
          cnt_d[i]    = cnt_q[i] + CNT_ONE;
        end
      end else begin
        cnt_d[i] = CNT_ZERO;
      end
    end
    // Taken from the next-state pulses so it lands in the same cycle as them.
    changed_d = |(rise_d | fall_d);
  end

  // State registers: synchronizer, counters, debounced levels and pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= {WIDTH{1'b0}};
      sync2_q   <= {WIDTH{1'b0}};
      stable_q  <= {WIDTH{1'b0}};
      rise_q    <= {WIDTH{1'b0}};
      fall_q    <= {WIDTH{1'b0}};
      changed_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
    end else begin
      sync1_q   <= sw_raw;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sw_stable  = stable_q;
  assign sw_rise    = rise_q;
  assign sw_fall    = fall_q;
  assign sw_changed = changed_q;

endmodule

// File: tb/tb_soc_system_sw_debounce.sv
// Bench for soc_system_sw_debounce: directed scenarios plus random switch activity,
// checked every cycle against a sample-history reference model.
module tb_soc_system_sw_debounce;

  localparam int W  = 10;
  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] sw_raw = 10'h000;
  logic [W-1:0] sw_stable, sw_rise, sw_fall;
  logic         sw_changed;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state: raw samples taken at each edge (0 while in reset).
  logic [W-1:0] hist [$];
  logic [W-1:0] m_stable = 10'h000;
  logic [W-1:0] m_rise   = 10'h000;
  logic [W-1:0] m_fall   = 10'h000;
  logic         m_changed = 1'b0;

  soc_system_sw_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .sw_raw    (sw_raw),
    .sw_stable (sw_stable),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .sw_changed(sw_changed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // A bit flips once the level two samples back has differed from the accepted
  // level for DC consecutive edges.
  task automatic model_edge();
    logic [W-1:0] nxt;
    bit           flip;
    if (reset) begin
      hist.delete();
      for (int k = 0; k < DC + 2; k++) hist.push_back(10'h000);
      m_stable  = 10'h000;
      m_rise    = 10'h000;
      m_fall    = 10'h000;
      m_changed = 1'b0;
    end else begin
      nxt    = m_stable;
      m_rise = 10'h000;
      m_fall = 10'h000;
      for (int b = 0; b < W; b++) begin
        flip = 1'b1;
        for (int k = 0; k < DC; k++)
          if (hist[hist.size() - 2 - k][b] == m_stable[b]) flip = 1'b0;
        if (flip) begin
          nxt[b] = ~m_stable[b];
          if (nxt[b]) m_rise[b] = 1'b1;
          else        m_fall[b] = 1'b1;
        end
      end
      m_changed = |(m_rise | m_fall);
      m_stable  = nxt;
      hist.push_back(sw_raw);
      if (hist.size() > DC + 4) void'(hist.pop_front());
    end
  endtask

  task automatic tick(input logic [W-1:0] raw, input logic rst);
    @(negedge clk);
    sw_raw = raw;
    reset  = rst;
    if (rst) begin
      #1;
      chk("rst_async_stable", sw_stable, 10'h000);
      chk("rst_async_rise", sw_rise, 10'h000);
      chk("rst_async_fall", sw_fall, 10'h000);
      chk("rst_async_changed", {9'h000, sw_changed}, 10'h000);
    end
    @(posedge clk);
    model_edge();
    #1;
    chk("model_stable", sw_stable, m_stable);
    chk("model_rise", sw_rise, m_rise);
    chk("model_fall", sw_fall, m_fall);
    chk("model_changed", {9'h000, sw_changed}, {9'h000, m_changed});
  endtask

  logic [W-1:0] seq3 [17];
  logic [W-1:0] r;

  initial begin
    for (int k = 0; k < DC + 2; k++) hist.push_back(10'h000);

    // 1: quiet after reset
    tick(10'h000, 1'b1);
    tick(10'h000, 1'b1);
    for (int c = 0; c < 50; c++) begin
      tick(10'h000, 1'b0);
      chk("t1_stable", sw_stable, 10'h000);
      chk("t1_changed", {9'h000, sw_changed}, 10'h000);
    end

    // 2: single clean rise, 6 edges latency
    for (int c = 1; c <= 5; c++) begin
      tick(10'h001, 1'b0);
      chk("t2_early_stable", sw_stable, 10'h000);
    end
    tick(10'h001, 1'b0);
    chk("t2_stable", sw_stable, 10'h001);
    chk("t2_rise", sw_rise, 10'h001);
    chk("t2_changed", {9'h000, sw_changed}, 10'h001);
    tick(10'h001, 1'b0);
    chk("t2_rise_gone", sw_rise, 10'h000);
    chk("t2_changed_gone", {9'h000, sw_changed}, 10'h000);

    // 3: bounce on bit 3 shorter than the debounce window
    for (int c = 0; c < 17; c++) seq3[c] = 10'h001;
    for (int c = 0; c < 3; c++) seq3[c] = 10'h009;
    for (int c = 4; c < 7; c++) seq3[c] = 10'h009;
    for (int c = 0; c < 17; c++) begin
      tick(seq3[c], 1'b0);
      chk("t3_stable", sw_stable, 10'h001);
      chk("t3_rise", sw_rise, 10'h000);
      chk("t3_fall", sw_fall, 10'h000);
    end

    // 4: all bits together
    for (int c = 0; c < 8; c++) tick(10'h000, 1'b0);
    chk("t4_cleared", sw_stable, 10'h000);
    for (int c = 1; c <= 5; c++) tick(10'h3FF, 1'b0);
    chk("t4_pre_stable", sw_stable, 10'h000);
    tick(10'h3FF, 1'b0);
    chk("t4_stable", sw_stable, 10'h3FF);
    chk("t4_rise", sw_rise, 10'h3FF);
    tick(10'h3FF, 1'b0);
    chk("t4_rise_gone", sw_rise, 10'h000);
    for (int c = 1; c <= 5; c++) tick(10'h155, 1'b0);
    chk("t4b_pre_stable", sw_stable, 10'h3FF);
    tick(10'h155, 1'b0);
    chk("t4b_stable", sw_stable, 10'h155);
    chk("t4b_fall", sw_fall, 10'h2AA);
    chk("t4b_rise", sw_rise, 10'h000);
    chk("t4b_changed", {9'h000, sw_changed}, 10'h001);

    // 5: switch held through reset is accepted DC+2 edges after release
    tick(10'h081, 1'b1);
    tick(10'h081, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      tick(10'h081, 1'b0);
      chk("t5_early_stable", sw_stable, 10'h000);
      chk("t5_early_rise", sw_rise, 10'h000);
    end
    tick(10'h081, 1'b0);
    chk("t5_stable", sw_stable, 10'h081);
    chk("t5_rise", sw_rise, 10'h081);
    tick(10'h081, 1'b0);
    chk("t5_rise_gone", sw_rise, 10'h000);

    // 6: reset while bit 5 is mid-count (cnt=2)
    for (int c = 0; c < 4; c++) tick(10'h0A1, 1'b0);
    chk("t6_midcount_stable", sw_stable, 10'h081);
    tick(10'h0A1, 1'b1);
    chk("t6_rst_stable", sw_stable, 10'h000);
    for (int c = 1; c <= 5; c++) begin
      tick(10'h0A1, 1'b0);
      chk("t6_early_stable", sw_stable, 10'h000);
    end
    tick(10'h0A1, 1'b0);
    chk("t6_stable", sw_stable, 10'h0A1);
    chk("t6_rise", sw_rise, 10'h0A1);

    // Random: sparse toggles give both bounces and settled runs; occasional reset
    r = 10'h0A1;
    for (int c = 0; c < 600; c++) begin
      r = r ^ W'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 59) == 0) tick(r, 1'b1);
      else                            tick(r, 1'b0);
    end
    for (int c = 0; c < 8; c++) tick(r, 1'b0);
    chk("final_settled", sw_stable, r);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
